// File: rtl/absorb_mem_pkg.sv
//------------------------------------------------------------------------------
// absorb_mem_pkg
//   Shared types and default sizing for the absorption memory controller.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package absorb_mem_pkg;

    localparam int DEF_ADDR_WIDTH = 16;
    localparam int DEF_WORD_WIDTH = 64;
    localparam int DEPTH          = 2 ** DEF_ADDR_WIDTH;
    localparam int LAST_ADDR      = DEPTH - 1;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_CLEAR      = 3'd1,
        ST_RUN        = 3'd2,
        ST_DRAIN      = 3'd3,
        ST_RD_REQ     = 3'd4,
        ST_RD_WAIT    = 3'd5,
        ST_RD_PRESENT = 3'd6
    } state_t;

endpackage

`default_nettype wire

// File: rtl/absorb_addr_seq.sv
//------------------------------------------------------------------------------
// absorb_addr_seq
//   Address walker shared by CLEAR and READOUT; saturates at the last word.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module absorb_addr_seq #(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clr,
    input  logic                  inc,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  last
);

    logic [ADDR_WIDTH-1:0] r_addr;

    always_ff @(posedge clock) begin
        if (reset || clr) begin
            r_addr <= '0;
        end else if (inc && !last) begin
            r_addr <= r_addr + 1'b1;
        end
    end

    assign addr = r_addr;
    assign last = &r_addr;

endmodule

`default_nettype wire

// File: rtl/absorb_mem_ctrl.sv
//------------------------------------------------------------------------------
// absorb_mem_ctrl
//   Run-phase sequencer and port mux for the Absorber's dual-port RAM.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module absorb_mem_ctrl
    import absorb_mem_pkg::*;
#(
    parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
    parameter int WORD_WIDTH    = DEF_WORD_WIDTH,
    parameter int READ_LAT      = 2,
    parameter int DRAIN_CYCLES  = 40,
    parameter int CLEAR_ON_READ = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cmd_clear,
    input  logic                  cmd_run,
    input  logic                  cmd_stop,
    input  logic                  cmd_readout,
    output logic                  busy,
    output logic                  done,
    output logic                  cmd_err,
    output logic                  inject_en,
    output logic                  pipe_enable,
    input  logic [WORD_WIDTH-1:0] abs_data,
    input  logic [ADDR_WIDTH-1:0] abs_rdaddress,
    input  logic [ADDR_WIDTH-1:0] abs_wraddress,
    input  logic                  abs_wren,
    output logic [WORD_WIDTH-1:0] abs_q,
    output logic [WORD_WIDTH-1:0] mem_data,
    output logic [ADDR_WIDTH-1:0] mem_rdaddress,
    output logic [ADDR_WIDTH-1:0] mem_wraddress,
    output logic                  mem_wren,
    input  logic [WORD_WIDTH-1:0] mem_q,
    output logic [WORD_WIDTH-1:0] rd_data,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_valid,
    input  logic                  rd_ready
);

    // One counter serves both the drain hold and the read-latency wait.
    localparam int c_CNT_MAX = (DRAIN_CYCLES > READ_LAT) ? DRAIN_CYCLES : READ_LAT;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
    localparam logic [c_CNT_W-1:0] c_DRAIN_END = c_CNT_W'(DRAIN_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_LAT_END   = c_CNT_W'(READ_LAT - 1);

    state_t                r_state;
    logic [c_CNT_W-1:0]    r_cnt;
    logic                  r_busy, r_done, r_cmd_err, r_inject_en, r_pipe_enable, r_rd_valid;
    logic [WORD_WIDTH-1:0] r_rd_data;
    logic [ADDR_WIDTH-1:0] r_rd_addr;

    logic [ADDR_WIDTH-1:0] w_addr;
    logic                  w_last, w_addr_clr, w_addr_inc, w_hs, w_pass, w_any_start, w_cmd_drop;

    assign w_pass      = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign w_hs        = (r_state == ST_RD_PRESENT) && r_rd_valid && rd_ready;
    assign w_any_start = cmd_clear | cmd_run | cmd_readout;
    assign w_cmd_drop  = (r_state == ST_IDLE) ? cmd_stop :
                         (r_state == ST_RUN)  ? w_any_start : (w_any_start | cmd_stop);
    assign w_addr_clr  = (r_state == ST_IDLE) && (cmd_clear || cmd_readout);
    assign w_addr_inc  = (r_state == ST_CLEAR) || w_hs;

    absorb_addr_seq #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_seq (
        .clock (clock),
        .reset (reset),
        .clr   (w_addr_clr),
        .inc   (w_addr_inc),
        .addr  (w_addr),
        .last  (w_last)
    );

    always_comb begin
        mem_data      = '0;
        mem_wraddress = w_addr;
        mem_rdaddress = w_addr;
        mem_wren      = 1'b0;
        if (w_pass) begin
            mem_data      = abs_data;
            mem_wraddress = abs_wraddress;
            mem_rdaddress = abs_rdaddress;
            mem_wren      = abs_wren;
        end else if (r_state == ST_CLEAR) begin
            mem_wren = 1'b1;
        end else if (w_hs) begin
            mem_wren = (CLEAR_ON_READ != 0);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_cmd_err     <= 1'b0;
            r_inject_en   <= 1'b0;
            r_pipe_enable <= 1'b0;
            r_rd_valid    <= 1'b0;
            r_rd_data     <= '0;
            r_rd_addr     <= '0;
        end else begin
            r_done    <= 1'b0;
            r_cmd_err <= w_cmd_drop;
            case (r_state)
                ST_IDLE: begin
                    if (cmd_clear) begin
                        r_state <= ST_CLEAR;
                        r_busy  <= 1'b1;
                    end else if (cmd_readout) begin
                        r_state <= ST_RD_REQ;
                        r_busy  <= 1'b1;
                    end else if (cmd_run) begin
                        r_state       <= ST_RUN;
                        r_busy        <= 1'b1;
                        r_inject_en   <= 1'b1;
                        r_pipe_enable <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (w_last) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (cmd_stop) begin
                        r_state     <= ST_DRAIN;
                        r_inject_en <= 1'b0;
                        r_cnt       <= '0;
                    end
                end
                ST_DRAIN: begin
                    if (r_cnt == c_DRAIN_END) begin
                        r_state       <= ST_IDLE;
                        r_busy        <= 1'b0;
                        r_done        <= 1'b1;
                        r_pipe_enable <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_RD_REQ: begin
                    r_state <= ST_RD_WAIT;
                    r_cnt   <= '0;
                end
                ST_RD_WAIT: begin
                    if (r_cnt == c_LAT_END) begin
                        r_state    <= ST_RD_PRESENT;
                        r_rd_data  <= mem_q;
                        r_rd_addr  <= w_addr;
                        r_rd_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_RD_PRESENT: begin
                    if (w_hs) begin
                        r_rd_valid <= 1'b0;
                        if (w_last) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_RD_REQ;
                        end
                    end
                end
                default: begin
                    r_state       <= ST_IDLE;
                    r_busy        <= 1'b0;
                    r_inject_en   <= 1'b0;
                    r_pipe_enable <= 1'b0;
                    r_rd_valid    <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign cmd_err     = r_cmd_err;
    assign inject_en   = r_inject_en;
    assign pipe_enable = r_pipe_enable;
    assign rd_valid    = r_rd_valid;
    assign rd_data     = r_rd_data;
    assign rd_addr     = r_rd_addr;
    assign abs_q       = mem_q;

endmodule

`default_nettype wire

// File: tb/tb_absorb_mem_ctrl.sv
//------------------------------------------------------------------------------
// tb_absorb_mem_ctrl
//   Self-checking bench: RAM model plus a shadow copy of expected contents.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_absorb_mem_ctrl;

    localparam int AW    = 4;
    localparam int WW    = 64;
    localparam int DEPTH = 16;
    localparam int DRAIN = 40;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_clear, cmd_run, cmd_stop, cmd_readout;
    logic          busy, done, cmd_err, inject_en, pipe_enable;
    logic [WW-1:0] abs_data, abs_q, mem_data, mem_q, rd_data;
    logic [AW-1:0] abs_rdaddress, abs_wraddress, mem_rdaddress, mem_wraddress, rd_addr;
    logic          abs_wren, mem_wren, rd_valid, rd_ready;

    int            n_cmp = 0;
    int            n_bad = 0;
    logic [WW-1:0] ref_mem [DEPTH];

    // Two-cycle read-latency RAM seen by the controller
    logic [WW-1:0] ram [DEPTH];
    logic [WW-1:0] ram_q1;

    always #5 clock = ~clock;

    always_ff @(posedge clock) begin
        if (mem_wren) ram[mem_wraddress] <= mem_data;
        ram_q1 <= ram[mem_rdaddress];
        mem_q  <= ram_q1;
    end

    absorb_mem_ctrl #(
        .ADDR_WIDTH    (AW),
        .WORD_WIDTH    (WW),
        .READ_LAT      (2),
        .DRAIN_CYCLES  (DRAIN),
        .CLEAR_ON_READ (1)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .cmd_clear     (cmd_clear),
        .cmd_run       (cmd_run),
        .cmd_stop      (cmd_stop),
        .cmd_readout   (cmd_readout),
        .busy          (busy),
        .done          (done),
        .cmd_err       (cmd_err),
        .inject_en     (inject_en),
        .pipe_enable   (pipe_enable),
        .abs_data      (abs_data),
        .abs_rdaddress (abs_rdaddress),
        .abs_wraddress (abs_wraddress),
        .abs_wren      (abs_wren),
        .abs_q         (abs_q),
        .mem_data      (mem_data),
        .mem_rdaddress (mem_rdaddress),
        .mem_wraddress (mem_wraddress),
        .mem_wren      (mem_wren),
        .mem_q         (mem_q),
        .rd_data       (rd_data),
        .rd_addr       (rd_addr),
        .rd_valid      (rd_valid),
        .rd_ready      (rd_ready)
    );

    task automatic check_eq(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // Fills word k with k+1 through a RUN/DRAIN session
    task automatic preload();
        cmd_run = 1'b1;
        cyc();
        cmd_run = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            abs_wren      = 1'b1;
            abs_wraddress = AW'(k);
            abs_data      = WW'(k + 1);
            ref_mem[k]    = WW'(k + 1);
            cyc();
        end
        abs_wren = 1'b0;
        cmd_stop = 1'b1;
        cyc();
        cmd_stop = 1'b0;
        repeat (DRAIN) cyc();
        check_eq("preload_done", done, 1);
    endtask

    task automatic do_readout(input bit stall3);
        int k, guard, stall;
        bit rdy;
        cmd_readout = 1'b1;
        cyc();
        cmd_readout = 1'b0;
        k = 0; guard = 0; stall = 0;
        while (k < DEPTH && guard < 600) begin
            check_eq("rd_done_early", done, 0);
            if (rd_valid && stall3 && k == 3 && stall < 10) begin
                rdy = 1'b0;
                stall++;
            end else begin
                rdy = 1'($urandom_range(0, 1));
            end
            rd_ready = rdy;
            #1;
            if (rd_valid) begin
                check_eq("rd_data", rd_data, ref_mem[k]);
                check_eq("rd_addr", rd_addr, WW'(k));
                check_eq("rd_hs_wren", mem_wren, rdy);
                if (rdy) begin
                    check_eq("rd_zero_addr", mem_wraddress, WW'(k));
                    check_eq("rd_zero_data", mem_data, 0);
                    ref_mem[k] = '0;
                    k++;
                end
            end else begin
                check_eq("rd_idle_wren", mem_wren, 0);
            end
            cyc();
            guard++;
        end
        rd_ready = 1'b0;
        check_eq("rd_word_count", WW'(k), WW'(DEPTH));
        if (stall3) check_eq("rd_stall_len", WW'(stall), 10);
        check_eq("rd_done", done, 1);
        check_eq("rd_busy_end", busy, 0);
        check_eq("rd_valid_end", rd_valid, 0);
        cyc();
        check_eq("rd_done_pulse", done, 0);
    endtask

    initial begin
        int n, dones, k, guard;
        cmd_clear = 0; cmd_run = 0; cmd_stop = 0; cmd_readout = 0;
        abs_data = '0; abs_rdaddress = '0; abs_wraddress = '0; abs_wren = 0; rd_ready = 0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

        repeat (3) cyc();
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_err", cmd_err, 0);
        check_eq("rst_inject", inject_en, 0);
        check_eq("rst_pipe", pipe_enable, 0);
        check_eq("rst_valid", rd_valid, 0);
        check_eq("rst_wren", mem_wren, 0);
        check_eq("rst_rd_data", rd_data, 0);
        check_eq("rst_rd_addr", rd_addr, 0);
        reset = 1'b0;
        cyc();

        // clear wins over run when both arrive together
        cmd_clear = 1'b1; cmd_run = 1'b1;
        cyc();
        cmd_clear = 1'b0; cmd_run = 1'b0;
        #1;
        check_eq("clr_busy", busy, 1);
        n = 0; dones = 0;
        for (int i = 0; i < 20; i++) begin
            check_eq("clr_inject", inject_en, 0);
            if (mem_wren) begin
                check_eq("clr_addr", mem_wraddress, WW'(n));
                check_eq("clr_data", mem_data, 0);
                n++;
            end
            if (done) dones++;
            cyc();
            #1;
        end
        check_eq("clr_words", WW'(n), WW'(DEPTH));
        check_eq("clr_dones", WW'(dones), 1);
        check_eq("clr_busy_end", busy, 0);

        cmd_run = 1'b1;
        cyc();
        cmd_run = 1'b0;
        #1;
        check_eq("run_inject", inject_en, 1);
        check_eq("run_pipe", pipe_enable, 1);
        check_eq("run_busy", busy, 1);
        abs_wren = 1'b1; abs_wraddress = 4'd5; abs_data = 64'h1234;
        #1;
        check_eq("run_wren", mem_wren, 1);
        check_eq("run_waddr", mem_wraddress, 5);
        check_eq("run_wdata", mem_data, 64'h1234);
        check_eq("run_absq", abs_q, mem_q);
        ref_mem[5] = 64'h1234;
        cyc();
        for (int i = 0; i < 24; i++) begin
            abs_wren      = 1'($urandom_range(0, 1));
            abs_wraddress = AW'($urandom_range(0, DEPTH - 1));
            abs_rdaddress = AW'($urandom_range(0, DEPTH - 1));
            abs_data      = {$urandom, $urandom};
            #1;
            check_eq("run_p_wren", mem_wren, abs_wren);
            check_eq("run_p_waddr", mem_wraddress, abs_wraddress);
            check_eq("run_p_raddr", mem_rdaddress, abs_rdaddress);
            check_eq("run_p_data", mem_data, abs_data);
            if (abs_wren) ref_mem[abs_wraddress] = abs_data;
            cyc();
        end
        abs_wren = 1'b0;

        cmd_readout = 1'b1;
        cyc();
        cmd_readout = 1'b0;
        check_eq("err_pulse", cmd_err, 1);
        check_eq("err_inject", inject_en, 1);
        check_eq("err_busy", busy, 1);
        cyc();
        check_eq("err_clear", cmd_err, 0);
        check_eq("err_still_run", inject_en, 1);

        cmd_stop = 1'b1;
        cyc();
        cmd_stop = 1'b0;
        for (int i = 0; i < DRAIN; i++) begin
            check_eq("drn_inject", inject_en, 0);
            check_eq("drn_pipe", pipe_enable, 1);
            check_eq("drn_done", done, 0);
            abs_wren      = 1'($urandom_range(0, 1));
            abs_wraddress = AW'($urandom_range(0, DEPTH - 1));
            abs_data      = {$urandom, $urandom};
            #1;
            check_eq("drn_wren", mem_wren, abs_wren);
            check_eq("drn_waddr", mem_wraddress, abs_wraddress);
            check_eq("drn_data", mem_data, abs_data);
            if (abs_wren) ref_mem[abs_wraddress] = abs_data;
            cyc();
        end
        abs_wren = 1'b1; abs_data = 64'hDEAD;
        #1;
        check_eq("drn_end_done", done, 1);
        check_eq("drn_end_busy", busy, 0);
        check_eq("drn_end_pipe", pipe_enable, 0);
        check_eq("idle_ignores_abs", mem_wren, 0);
        abs_wren = 1'b0;
        cyc();
        check_eq("drn_done_pulse", done, 0);

        do_readout(1'b0);
        preload();
        do_readout(1'b1);
        do_readout(1'b0);

        // abort a readout with reset while word 7 is presented
        preload();
        cmd_readout = 1'b1;
        cyc();
        cmd_readout = 1'b0;
        k = 0; guard = 0;
        while (!(rd_valid && k == 7) && guard < 300) begin
            rd_ready = rd_valid;
            if (rd_valid) begin
                ref_mem[k] = '0;
                k++;
            end
            cyc();
            guard++;
        end
        rd_ready = 1'b0;
        check_eq("rst7_reached", WW'(k), 7);
        check_eq("rst7_addr", rd_addr, 7);
        check_eq("rst7_data", rd_data, ref_mem[7]);
        reset = 1'b1;
        cyc();
        #1;
        check_eq("rst7_busy", busy, 0);
        check_eq("rst7_valid", rd_valid, 0);
        check_eq("rst7_wren", mem_wren, 0);
        check_eq("rst7_done", done, 0);
        reset = 1'b0;
        repeat (3) begin
            cyc();
            check_eq("rst7_no_done", done, 0);
            check_eq("rst7_idle", busy, 0);
        end
        do_readout(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
